// File: rtl/debounce_toggle_multi.sv
// N-channel switch conditioner: 2-flop synchroniser, stability-count debounce,
// registered press/release pulses and a per-channel toggle flag for LED drive.
module debounce_toggle_multi #(
   parameter int   NUM_CH            = 4,
   parameter int   DEBOUNCE_LIMIT    = 250000,
   parameter logic INIT_LEVEL        = 1'b0,
   parameter logic TOGGLE_ON_RELEASE = 1'b0
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   input  logic [NUM_CH-1:0] i_Switch,
   output logic [NUM_CH-1:0] o_Debounced,
   output logic [NUM_CH-1:0] o_Press,
   output logic [NUM_CH-1:0] o_Release,
   output logic [NUM_CH-1:0] o_Toggle
);

   localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

   genvar n;
   generate
      for (n = 0; n < NUM_CH; n++) begin : g_ch
         logic             sync1_q, sync2_q;
         logic             deb_q, deb_d;
         logic             press_q, press_d;
         logic             rel_q, rel_d;
         logic             tog_q, tog_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;

         // Any sample matching the current level clears the run: no partial credit.
         always_comb begin
            cnt_d   = '0;
            deb_d   = deb_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            tog_d   = tog_q;
            if (sync2_q != deb_q) begin
               if (cnt_q == CNT_LAST) begin
                  deb_d   = sync2_q;
                  press_d = (sync2_q != INIT_LEVEL);
                  rel_d   = (sync2_q == INIT_LEVEL);
                  if (TOGGLE_ON_RELEASE ? rel_d : press_d) begin
                     tog_d = ~tog_q;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
               sync1_q <= INIT_LEVEL;
               sync2_q <= INIT_LEVEL;
               deb_q   <= INIT_LEVEL;
               cnt_q   <= '0;
               press_q <= 1'b0;
               rel_q   <= 1'b0;
               tog_q   <= 1'b0;
            end else begin
               sync1_q <= i_Switch[n];
               sync2_q <= sync1_q;
               deb_q   <= deb_d;
               cnt_q   <= cnt_d;
               press_q <= press_d;
               rel_q   <= rel_d;
               tog_q   <= tog_d;
            end
         end

         assign o_Debounced[n] = deb_q;
         assign o_Press[n]     = press_q;
         assign o_Release[n]   = rel_q;
         assign o_Toggle[n]    = tog_q;
      end
   endgenerate

endmodule

// File: tb/tb_debounce_toggle_multi.sv
// Scoreboard bench: two configurations checked cycle-by-cycle against a window-based
// reference model, plus directed latency checks on press pulses.
module tb_debounce_toggle_multi;

   logic       clk;
   logic       rst;
   logic [3:0] sw_a;
   logic [1:0] sw_b;
   logic [3:0] deb_a, pr_a, rel_a, tog_a;
   logic [1:0] deb_b, pr_b, rel_b, tog_b;

   int checks = 0;
   int errors = 0;

   debounce_toggle_multi #(
      .NUM_CH(4), .DEBOUNCE_LIMIT(4), .INIT_LEVEL(1'b0), .TOGGLE_ON_RELEASE(1'b0)
   ) dut_a (
      .i_Clk(clk), .i_Reset(rst), .i_Switch(sw_a),
      .o_Debounced(deb_a), .o_Press(pr_a), .o_Release(rel_a), .o_Toggle(tog_a)
   );

   debounce_toggle_multi #(
      .NUM_CH(2), .DEBOUNCE_LIMIT(8), .INIT_LEVEL(1'b1), .TOGGLE_ON_RELEASE(1'b1)
   ) dut_b (
      .i_Clk(clk), .i_Reset(rst), .i_Switch(sw_b),
      .o_Debounced(deb_b), .o_Press(pr_b), .o_Release(rel_b), .o_Toggle(tog_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int lim(input int d);  return (d == 0) ? 4 : 8; endfunction
   function automatic bit init(input int d); return (d == 0) ? 1'b0 : 1'b1; endfunction
   function automatic bit tor(input int d);  return (d == 0) ? 1'b0 : 1'b1; endfunction
   function automatic int nch(input int d);  return (d == 0) ? 4 : 2; endfunction

   function automatic bit sw_bit(input int d, input int ch);
      logic [3:0] v;
      v = (d == 0) ? sw_a : {2'b00, sw_b};
      return v[ch];
   endfunction

   function automatic logic [3:0] get_press(input int d);
      return (d == 0) ? pr_a : {2'b00, pr_b};
   endfunction

   function automatic logic [15:0] actual(input int d);
      if (d == 0) return {deb_a, pr_a, rel_a, tog_a};
      return {2'b00, deb_b, 2'b00, pr_b, 2'b00, rel_b, 2'b00, tog_b};
   endfunction

   // Reference model: the synchronised input is the switch value seen two edges
   // earlier; the level flips once the last LIMIT synchronised samples all differ from it.
   bit m_deb [2][4];
   bit m_tog [2][4];
   bit m_dly [2][4][2];
   bit m_win [2][4][8];
   logic [15:0] exp_a[$];
   logic [15:0] exp_b[$];
   bit started = 1'b0;

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic [3:0] ed, ep, er, et;
         bit s, all_diff;
         ed = '0; ep = '0; er = '0; et = '0;
         for (int ch = 0; ch < nch(d); ch++) begin
            if (rst) begin
               m_deb[d][ch] = init(d);
               m_tog[d][ch] = 1'b0;
               m_dly[d][ch][0] = init(d);
               m_dly[d][ch][1] = init(d);
               for (int k = 0; k < 8; k++) m_win[d][ch][k] = init(d);
            end else begin
               s = m_dly[d][ch][0];
               m_dly[d][ch][0] = m_dly[d][ch][1];
               m_dly[d][ch][1] = sw_bit(d, ch);
               for (int k = 0; k < lim(d) - 1; k++) m_win[d][ch][k] = m_win[d][ch][k+1];
               m_win[d][ch][lim(d)-1] = s;
               all_diff = 1'b1;
               for (int k = 0; k < lim(d); k++)
                  if (m_win[d][ch][k] == m_deb[d][ch]) all_diff = 1'b0;
               if (all_diff) begin
                  m_deb[d][ch] = s;
                  if (s != init(d)) ep[ch] = 1'b1;
                  else              er[ch] = 1'b1;
                  if (tor(d) ? er[ch] : ep[ch]) m_tog[d][ch] = ~m_tog[d][ch];
               end
            end
            ed[ch] = m_deb[d][ch];
            et[ch] = m_tog[d][ch];
         end
         if (d == 0) exp_a.push_back({ed, ep, er, et});
         else        exp_b.push_back({ed, ep, er, et});
      end
      started = 1'b1;
   end

   // Monitor: outputs are presented every cycle; compare away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         for (int d = 0; d < 2; d++) begin
            logic [15:0] e, a;
            checks++;
            if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
               errors++;
               $display("FAIL scoreboard_empty dut%0d at %0t", d, $time);
            end else begin
               e = (d == 0) ? exp_a.pop_front() : exp_b.pop_front();
               a = actual(d);
               if (a !== e) begin
                  errors++;
                  $display("FAIL scoreboard dut%0d at %0t: got deb=%b press=%b rel=%b tog=%b, expected deb=%b press=%b rel=%b tog=%b",
                           d, $time, a[15:12], a[11:8], a[7:4], a[3:0], e[15:12], e[11:8], e[7:4], e[3:0]);
               end
            end
         end
      end
   end

   // Caller changes inputs just before edge 0; expects the first press pulse at exp_edge.
   task automatic expect_press_at(input int d, input logic [3:0] mask, input int exp_edge, input string name);
      int seen;
      seen = -1;
      for (int e = 0; e < 30 && seen < 0; e++) begin
         @(posedge clk);
         #1;
         if (get_press(d) != 4'b0000) begin
            seen = e;
            checks++;
            if (get_press(d) !== mask || e != exp_edge) begin
               errors++;
               $display("FAIL %s: press=%b at edge %0d, expected %b at edge %0d",
                        name, get_press(d), e, mask, exp_edge);
            end
         end
      end
      if (seen < 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no press within 30 edges, expected %b at edge %0d", name, mask, exp_edge);
      end
   endtask

   int hold_a [4];
   int hold_b [2];

   initial begin
      rst  = 1'b1;
      sw_a = 4'b0000;
      sw_b = 2'b11;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // single channel press, channel 1 idle
      sw_a = 4'b0001;
      expect_press_at(0, 4'b0001, 5, "press_latency");
      @(negedge clk);
      repeat (20) @(negedge clk);
      sw_a = 4'b0000;
      repeat (12) @(negedge clk);

      // bounce: 3 high, 1 low, then steady high
      sw_a = 4'b0010;
      repeat (3) @(negedge clk);
      sw_a = 4'b0000;
      @(negedge clk);
      sw_a = 4'b0010;
      expect_press_at(0, 4'b0010, 5, "bounce_latency");
      @(negedge clk);
      sw_a = 4'b0000;
      repeat (12) @(negedge clk);

      // second press on channel 0 toggles it back
      sw_a = 4'b0001;
      expect_press_at(0, 4'b0001, 5, "second_press");
      @(negedge clk);
      sw_a = 4'b0000;
      repeat (12) @(negedge clk);

      // all channels together
      sw_a = 4'b1111;
      expect_press_at(0, 4'b1111, 5, "simul_press");
      @(negedge clk);
      sw_a = 4'b0000;
      repeat (12) @(negedge clk);

      // reset mid-count on the LIMIT=8, idle-high config: count reaches 5, then reset
      sw_b = 2'b10;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      expect_press_at(1, 4'b0001, 9, "reset_restart");
      @(negedge clk);
      repeat (5) @(negedge clk);
      sw_b = 2'b11;
      repeat (20) @(negedge clk);

      // randomized switching with runs both shorter and longer than the limits
      for (int c = 0; c < 4; c++) hold_a[c] = $urandom_range(1, 12);
      for (int c = 0; c < 2; c++) hold_b[c] = $urandom_range(1, 20);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         for (int c = 0; c < 4; c++) begin
            if (hold_a[c] == 0) begin
               sw_a[c]   = ~sw_a[c];
               hold_a[c] = $urandom_range(1, 12);
            end else begin
               hold_a[c]--;
            end
         end
         for (int c = 0; c < 2; c++) begin
            if (hold_b[c] == 0) begin
               sw_b[c]   = ~sw_b[c];
               hold_b[c] = $urandom_range(1, 20);
            end else begin
               hold_b[c]--;
            end
         end
         rst = ($urandom_range(0, 399) == 0);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/debounce_toggle_multi.md
Name: debounce_toggle_multi

Overview:
- N-channel successor to the single-switch debounce-plus-LED-toggle chain.
- Per channel the block does four things:
  - synchronises a raw switch input;
  - debounces it with a parametrised stability count;
  - emits one-cycle press/release pulses;
  - keeps a toggle flag that drives an LED directly.
- Sits between board switch pins and the user logic in the top level, replacing one debounce instance plus one toggle instance per switch.

Parameters:
- NUM_CH, 4, number of independent switch channels (>=1).
- DEBOUNCE_LIMIT, 250000, consecutive stable cycles required before the debounced level changes (>=1).
- INIT_LEVEL, 0, reset value of the synchroniser and debounced level for every channel (switch idle level).
- TOGGLE_ON_RELEASE, 0:
  - 0: toggle on a debounced transition away from INIT_LEVEL (press).
  - 1: toggle on a transition back to INIT_LEVEL (release).

Ports:
- i_Clk  in  1  system clock; all logic on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Switch  in  NUM_CH  raw asynchronous switch inputs; bit n is channel n.
- o_Debounced  out  NUM_CH  debounced level per channel.
- o_Press  out  NUM_CH  one-cycle pulse when debounced level leaves INIT_LEVEL.
- o_Release  out  NUM_CH  one-cycle pulse when debounced level returns to INIT_LEVEL.
- o_Toggle  out  NUM_CH  per-channel toggle flag (LED drive).

Behaviour:
- Clocking and reset:
  - Single clock domain, i_Clk.
  - Reset is synchronous and active-high, sampled only on the i_Clk rising edge.
- Reset values, all channels:
  - sync stages = INIT_LEVEL;
  - o_Debounced = INIT_LEVEL;
  - counter = 0;
  - o_Press = o_Release = 0;
  - o_Toggle = 0.
- Reset is effective on the edge it is sampled. It wins over every other event on that edge, including a counter reaching its limit.
- Synchroniser: two flops per channel, stage1 <= i_Switch[n], stage2 <= stage1. Only stage2 feeds the debounce logic.
- Debounce counter per channel:
  - Width = max(1, clog2(DEBOUNCE_LIMIT)).
  - Each edge, evaluated in priority order:
    - stage2 == o_Debounced: counter <= 0.
    - stage2 != o_Debounced and counter < DEBOUNCE_LIMIT-1: counter <= counter+1.
    - stage2 != o_Debounced and counter == DEBOUNCE_LIMIT-1: o_Debounced <= stage2, counter <= 0.
- Any bounce (stage2 returning to o_Debounced) before the limit clears the count. There is no partial credit.
- Latency:
  - Edge 0 is the first edge sampling a new stable i_Switch value.
  - o_Debounced changes at edge DEBOUNCE_LIMIT+1.
  - Example: LIMIT=1 gives o_Debounced change at edge 2.
- Edge pulses are registered and asserted for exactly one cycle, on the same edge o_Debounced changes:
  - o_Press[n]=1 when the new level != INIT_LEVEL.
  - o_Release[n]=1 when the new level == INIT_LEVEL.
  - Both are 0 on all other cycles.
  - o_Press and o_Release are never high together on one channel.
- Toggle: o_Toggle[n] inverts on the same edge o_Press[n] rises (TOGGLE_ON_RELEASE=0) or o_Release[n] rises (=1). It is held otherwise.
- Channels are fully independent. Simultaneous transitions on several channels are each processed on their own counters with identical timing.
- No spurious pulse after reset when i_Switch already equals INIT_LEVEL.
- If i_Switch != INIT_LEVEL at reset release, that channel debounces normally and produces one press pulse/toggle at edge DEBOUNCE_LIMIT+1 after reset deassertion. This is intentional.
- Reset mid-count discards the count. Counting restarts from 0 after reset.
- Input pulses shorter than DEBOUNCE_LIMIT cycles (post-synchroniser) never reach o_Debounced.

Test Plan:
1. NUM_CH=2, LIMIT=4, INIT_LEVEL=0.
   - Stimulus: i_Switch[0] 0->1, held.
   - Response: o_Debounced[0]=1 and o_Press[0]=1 for one cycle at edge 5; o_Toggle[0] 0->1 at edge 5; channel 1 outputs stay 0.
2. Bounce, LIMIT=4.
   - Stimulus: i_Switch[0] high 3 cycles, low 1 cycle, then high steady.
   - Response: no change at the early edges; o_Debounced[0] rises at edge 5 counted from the final rising sample; exactly one o_Press pulse.
3. Full press/release, TOGGLE_ON_RELEASE=0, LIMIT=4.
   - Stimulus: press, then release after 20 cycles.
   - Response: o_Release[0] pulses 5 edges after the release sample; o_Toggle[0] unchanged by the release; a second press returns o_Toggle[0] to 0.
4. TOGGLE_ON_RELEASE=1.
   - Stimulus: same sequence as scenario 3.
   - Response: o_Toggle[0] stays 0 on the press; flips to 1 on the same edge as o_Release[0].
5. Reset mid-count, LIMIT=8.
   - Stimulus: assert i_Reset for 1 cycle when the counter = 5, with the switch held high.
   - Response: all outputs show reset values on the next edge; o_Press fires 9 edges after reset deassertion, not earlier.
6. Simultaneous channels, NUM_CH=4.
   - Stimulus: all four i_Switch bits rise on the same edge.
   - Response: o_Press = 4'b1111 for exactly one cycle at edge LIMIT+1; o_Toggle = 4'b1111.
